// File: rtl/asic_dout_capture.sv
// rtl/asic_dout_capture.sv - ASIC output bus capture: synchronise, frame on start, pack per dclk edge into a FIFO read over Avalon-MM
module asic_dout_capture #(
  parameter int DATA_W      = 7,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              asic_dclk,
  input  logic [DATA_W-1:0] asic_dout1,
  input  logic [DATA_W-1:0] asic_dout2,
  input  logic              asic_bitout1,
  input  logic              asic_bitout2,
  input  logic              asic_start,
  input  logic              asic_testready,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = 2 * DATA_W + 2;
  localparam int IN_W   = WORD_W + 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // All ASIC inputs share one synchroniser chain so data and strobe see identical delay
  logic [IN_W-1:0] async_in;
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] s;

  assign async_in = {asic_testready, asic_start, asic_dclk,
                     asic_bitout2, asic_bitout1, asic_dout2, asic_dout1};
  assign s = sync_q[SYNC_STAGES-1];

  logic [WORD_W-1:0] word;
  logic              sync_dclk, sync_start, sync_testready;
  logic              dclk_d, start_d;
  logic              dclk_rise, start_rise;

  assign word           = s[WORD_W-1:0];
  assign sync_dclk      = s[WORD_W];
  assign sync_start     = s[WORD_W+1];
  assign sync_testready = s[WORD_W+2];
  assign dclk_rise      = sync_dclk & ~dclk_d;
  assign start_rise     = sync_start & ~start_d;

  // Synchroniser shift chain and edge-detect delay flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dclk_d  <= 1'b0;
      start_d <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dclk_d  <= sync_dclk;
      start_d <= sync_start;
    end
  end

  // Register access decode; flush outranks abort, which outranks arm
  logic wr_ctrl, ctrl_flush, ctrl_abort, ctrl_arm, ctrl_clr_ovf;
  logic wr_len, rd_data;

  assign wr_ctrl      = avs_write && (avs_address == 2'd0);
  assign ctrl_flush   = wr_ctrl && avs_writedata[1];
  assign ctrl_abort   = wr_ctrl && avs_writedata[3] && !ctrl_flush;
  assign ctrl_arm     = wr_ctrl && avs_writedata[0] && !ctrl_flush && !avs_writedata[3];
  assign ctrl_clr_ovf = wr_ctrl && avs_writedata[2];
  assign wr_len       = avs_write && (avs_address == 2'd1);
  assign rd_data      = avs_read && (avs_address == 2'd2);

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:16];

  state_t      state, state_next;
  logic [15:0] frame_len, captured;
  logic        overflow;

  // FIFO storage and pointers; extra pointer bit distinguishes full from empty
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr, rptr, level;
  logic              full, empty, pop, push_en;

  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign pop   = rd_data && !empty;

  // Frame counting: the count restarts from zero on the cycle a frame opens
  logic        capturing, cap_push, done_hit;
  logic [15:0] cnt_base, cnt_next;

  assign cnt_base = (state == ARMED) ? 16'd0 : captured;
  assign cnt_next = (cap_push && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
  assign done_hit = cap_push && (frame_len != 16'd0) && (cnt_next == frame_len);
  assign push_en  = cap_push && (!full || pop);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (ctrl_flush || ctrl_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (ctrl_arm) state_next = ARMED;
        ARMED:   if (start_rise) state_next = done_hit ? DONE : CAPTURE;
        CAPTURE: if (done_hit) state_next = DONE;
        DONE:    if (ctrl_arm) state_next = ARMED;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs: when the counter tracks and when a dclk edge becomes a push
  always_comb begin
    capturing = 1'b0;
    if (!ctrl_flush && !ctrl_abort) begin
      case (state)
        ARMED:   capturing = start_rise;
        CAPTURE: capturing = 1'b1;
        default: capturing = 1'b0;
      endcase
    end
    cap_push = capturing && dclk_rise;
  end

  // Capture counter, frame length register and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      captured  <= 16'd0;
      frame_len <= 16'd0;
      overflow  <= 1'b0;
    end else begin
      if (capturing) captured <= cnt_next;
      if (wr_len) frame_len <= avs_writedata[15:0];
      if (ctrl_clr_ovf) overflow <= 1'b0;
      if (cap_push && full && !pop) overflow <= 1'b1;
    end
  end

  // FIFO pointer update; flush empties the FIFO regardless of traffic that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (ctrl_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // FIFO data array write
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr[AW-1:0]] <= word;
  end

  // Registered read mux, one cycle after avs_read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0: avs_readdata <= {state, sync_testready, 10'd0, overflow, full, empty,
                               {(15-AW){1'b0}}, level};
        2'd1: avs_readdata <= {16'd0, frame_len};
        2'd2: avs_readdata <= empty ? 32'd0
                                    : {1'b1, {(31-WORD_W){1'b0}}, mem[rptr[AW-1:0]]};
        default: avs_readdata <= {16'd0, captured};
      endcase
    end
  end

endmodule

// File: tb/tb_asic_dout_capture.sv
// tb/tb_asic_dout_capture.sv - directed self-checking bench for asic_dout_capture
module tb_asic_dout_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        asic_dclk = 1'b0;
  logic [6:0]  asic_dout1 = '0;
  logic [6:0]  asic_dout2 = '0;
  logic        asic_bitout1 = 1'b0;
  logic        asic_bitout2 = 1'b0;
  logic        asic_start = 1'b0;
  logic        asic_testready = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;

  int n_checks = 0;
  int n_fail = 0;

  asic_dout_capture #(.DATA_W(7), .DEPTH(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .asic_dclk(asic_dclk), .asic_dout1(asic_dout1), .asic_dout2(asic_dout2),
    .asic_bitout1(asic_bitout1), .asic_bitout2(asic_bitout2),
    .asic_start(asic_start), .asic_testready(asic_testready),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [6:0] d1, input logic [6:0] d2,
                                     input logic b1, input logic b2);
    return {1'b1, 15'd0, b2, b1, d2, d1};
  endfunction

  function automatic logic [31:0] stat(input logic [1:0] st, input logic tr, input logic ov,
                                       input logic fu, input logic em, input int lvl);
    return {st, tr, 10'd0, ov, fu, em, lvl[15:0]};
  endfunction

  function automatic logic [31:0] exp_ov(input int i);
    logic [7:0] v;
    v = i[7:0];
    return pk(v[6:0], ~v[6:0], v[0], v[1]);
  endfunction

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic dclk_edge(input logic [6:0] d1, input logic [6:0] d2, input logic b1, input logic b2);
    @(negedge clk);
    asic_dout1 = d1; asic_dout2 = d2; asic_bitout1 = b1; asic_bitout2 = b2; asic_dclk = 1'b1;
    repeat (4) @(negedge clk);
    asic_dclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    asic_start = 1'b1;
    repeat (4) @(negedge clk);
    asic_start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ov_edge(input int i);
    logic [31:0] w;
    w = exp_ov(i);
    dclk_edge(w[6:0], w[13:7], w[14], w[15]);
  endtask

  logic [31:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_readdata", avs_readdata, 32'd0);
    reset = 1'b0;
    avs_rd(2'd0, rd); chk("reset_status", rd, stat(0, 0, 0, 0, 1, 0));
    avs_rd(2'd3, rd); chk("reset_captured", rd, 32'd0);

    asic_testready = 1'b1;
    repeat (4) @(negedge clk);
    avs_rd(2'd0, rd); chk("testready_sync", rd, stat(0, 1, 0, 0, 1, 0));
    asic_testready = 1'b0;
    repeat (4) @(negedge clk);

    // Basic frame of four words
    avs_wr(2'd1, 32'd4);
    avs_wr(2'd0, 32'h1);
    avs_rd(2'd0, rd); chk("armed_state", rd, stat(1, 0, 0, 0, 1, 0));
    start_pulse();
    for (int i = 0; i < 4; i++) dclk_edge(7'(8'h11 + i), 7'h7F, 1'b1, 1'b0);
    avs_rd(2'd0, rd); chk("basic_done", rd, stat(3, 0, 0, 0, 0, 4));
    avs_rd(2'd3, rd); chk("basic_captured", rd, 32'd4);
    for (int i = 0; i < 4; i++) begin
      avs_rd(2'd2, rd); chk("basic_word", rd, pk(7'(8'h11 + i), 7'h7F, 1'b1, 1'b0));
    end
    avs_rd(2'd2, rd); chk("basic_empty_read", rd, 32'd0);
    avs_rd(2'd0, rd); chk("basic_empty_status", rd, stat(3, 0, 0, 0, 1, 0));

    // Start and dclk rising together
    avs_wr(2'd0, 32'h2);
    avs_wr(2'd1, 32'd2);
    avs_wr(2'd0, 32'h1);
    @(negedge clk);
    asic_dout1 = 7'h55; asic_dout2 = 7'h2A; asic_bitout1 = 1'b0; asic_bitout2 = 1'b1;
    asic_start = 1'b1; asic_dclk = 1'b1;
    repeat (4) @(negedge clk);
    asic_start = 1'b0; asic_dclk = 1'b0;
    repeat (4) @(negedge clk);
    avs_rd(2'd3, rd); chk("coinc_captured", rd, 32'd1);
    avs_rd(2'd0, rd); chk("coinc_status", rd, stat(2, 0, 0, 0, 0, 1));
    avs_rd(2'd2, rd); chk("coinc_word", rd, pk(7'h55, 7'h2A, 1'b0, 1'b1));
    avs_wr(2'd0, 32'h8);

    // Unbounded frame overflowing the FIFO
    avs_wr(2'd0, 32'h2);
    avs_wr(2'd1, 32'd0);
    avs_wr(2'd0, 32'h1);
    start_pulse();
    for (int i = 0; i < 70; i++) ov_edge(i);
    avs_rd(2'd0, rd); chk("ovf_status", rd, stat(2, 0, 1, 1, 0, 64));
    avs_rd(2'd3, rd); chk("ovf_captured", rd, 32'd70);
    avs_rd(2'd2, rd); chk("ovf_first_word", rd, exp_ov(0));
    avs_wr(2'd0, 32'h4);
    avs_rd(2'd0, rd); chk("ovf_cleared", rd, stat(2, 0, 0, 0, 0, 63));
    ov_edge(70);
    avs_rd(2'd0, rd); chk("refill_full", rd, stat(2, 0, 0, 1, 0, 64));

    // Pop and push in the same cycle while full
    @(negedge clk);
    begin
      logic [31:0] w;
      w = exp_ov(71);
      asic_dout1 = w[6:0]; asic_dout2 = w[13:7]; asic_bitout1 = w[14]; asic_bitout2 = w[15];
      asic_dclk = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    avs_address = 2'd2; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    chk("pushpop_word", avs_readdata, exp_ov(1));
    repeat (2) @(negedge clk);
    asic_dclk = 1'b0;
    repeat (3) @(negedge clk);
    avs_rd(2'd0, rd); chk("pushpop_status", rd, stat(2, 0, 0, 1, 0, 64));
    avs_rd(2'd2, rd); chk("pushpop_order", rd, exp_ov(2));

    // Control behaviour
    avs_wr(2'd0, 32'h1);
    avs_rd(2'd0, rd); chk("arm_in_capture", rd, stat(2, 0, 0, 0, 0, 63));
    avs_wr(2'd0, 32'h8);
    avs_rd(2'd0, rd); chk("abort_keeps_fifo", rd, stat(0, 0, 0, 0, 0, 63));
    avs_rd(2'd2, rd); chk("abort_word", rd, exp_ov(3));
    avs_wr(2'd0, 32'h3);
    avs_rd(2'd0, rd); chk("flush_beats_arm", rd, stat(0, 0, 0, 0, 1, 0));

    // Reset in the middle of a frame
    avs_wr(2'd1, 32'd8);
    avs_wr(2'd0, 32'h1);
    start_pulse();
    for (int i = 0; i < 3; i++) dclk_edge(7'(8'h20 + i), 7'(i), i[0], 1'b1);
    avs_rd(2'd3, rd); chk("pre_reset_captured", rd, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_reset_readdata", avs_readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    avs_rd(2'd0, rd); chk("post_reset_status", rd, stat(0, 0, 0, 0, 1, 0));
    avs_rd(2'd3, rd); chk("post_reset_captured", rd, 32'd0);
    avs_rd(2'd1, rd); chk("post_reset_frame_len", rd, 32'd0);
    avs_wr(2'd1, 32'd8);
    avs_wr(2'd0, 32'h1);
    start_pulse();
    for (int i = 0; i < 8; i++) dclk_edge(7'(8'h20 + i), 7'(i), i[0], 1'b1);
    avs_rd(2'd0, rd); chk("rerun_done", rd, stat(3, 0, 0, 0, 0, 8));
    for (int i = 0; i < 8; i++) begin
      avs_rd(2'd2, rd); chk("rerun_word", rd, pk(7'(8'h20 + i), 7'(i), i[0], 1'b1));
    end
    avs_rd(2'd0, rd); chk("rerun_empty", rd, stat(3, 0, 0, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
